packet_fifo_reader: RTL and testbench



---
 rtl/packet_fifo_reader_pkg.sv | 10 +
 rtl/packet_reader_skid_buffer.sv | 53 +++++
 rtl/packet_fifo_reader.sv | 143 ++++++++++++++
 tb/tb_packet_fifo_reader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/packet_fifo_reader_pkg.sv
// Shared types for the packet FIFO drain engine.
package packet_fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    POP  = 2'd2
  } state_t;

endpackage

// File: rtl/packet_reader_skid_buffer.sv
// Small register-based FIFO that absorbs read data already in flight from the
// packet memory; exposes the head entry, occupancy and an empty flag.
module packet_reader_skid_buffer #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_rd;

  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = mem_reg[rd_ptr_reg];
  assign do_rd = rd_en && !empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_en) begin
        mem_reg[wr_ptr_reg] <= wr_data;
        wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
      end
      if (do_rd) begin
        rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
      end
      case ({wr_en, do_rd})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/packet_fifo_reader.sv
// Drains whole committed packets from the packet FIFO read port into a
// valid/ready stream with a last flag, using credits to bound in-flight reads.
module packet_fifo_reader
  import packet_fifo_reader_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 1024,
  parameter int ADDR_BITS    = $clog2(DEPTH),
  parameter int READ_LATENCY = 2,
  parameter int SKID_DEPTH   = READ_LATENCY + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 len_valid,
  input  logic [ADDR_BITS:0]   len_data,
  output logic                 len_pop,
  input  logic [ADDR_BITS:0]   fifo_rd_size,
  output logic                 fifo_rd_en,
  output logic [ADDR_BITS-1:0] fifo_rd_offset,
  output logic                 fifo_rd_pop_packet,
  output logic [ADDR_BITS:0]   fifo_rd_packet_size,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int CW = $clog2(SKID_DEPTH) + 1;
  localparam logic [ADDR_BITS:0] MAX_LEN = (ADDR_BITS + 1)'(DEPTH);

  state_t state_reg, state_next;
  logic [ADDR_BITS:0]      pkt_len_reg;
  logic [ADDR_BITS:0]      issue_cnt_reg;
  logic [READ_LATENCY-1:0] pipe_valid_reg;
  logic [READ_LATENCY-1:0] pipe_last_reg;

  logic          start;
  logic          rd_en;
  logic          pop;
  logic          last_issue;
  logic          credit_ok;
  logic [CW-1:0] inflight;
  logic [CW-1:0] skid_count;
  logic          skid_empty;
  logic [WIDTH:0] skid_head;

  assign last_issue = (issue_cnt_reg == pkt_len_reg - 1'b1);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + CW'(pipe_valid_reg[i]);
  end

  // Every issued read has a guaranteed skid slot by the time its data lands.
  assign credit_ok = (inflight + skid_count) < CW'(SKID_DEPTH);

  always_comb begin
    state_next = state_reg;
    len_pop    = 1'b0;
    start      = 1'b0;
    rd_en      = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        // Gated by reset so a pending length is never consumed while held in reset.
        if (len_valid && !reset) begin
          if (len_data == '0) begin
            len_pop = 1'b1;
          end else if (len_data <= MAX_LEN && fifo_rd_size >= len_data) begin
            len_pop    = 1'b1;
            start      = 1'b1;
            state_next = READ;
          end
        end
      end
      READ: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          if (last_issue) state_next = POP;
        end
      end
      POP: begin
        pop        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      pkt_len_reg    <= '0;
      issue_cnt_reg  <= '0;
      pipe_valid_reg <= '0;
      pipe_last_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        pkt_len_reg   <= len_data;
        issue_cnt_reg <= '0;
      end else if (rd_en) begin
        issue_cnt_reg <= issue_cnt_reg + 1'b1;
      end
      pipe_valid_reg[0] <= rd_en;
      pipe_last_reg[0]  <= rd_en && last_issue;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_valid_reg[i] <= pipe_valid_reg[i-1];
        pipe_last_reg[i]  <= pipe_last_reg[i-1];
      end
    end
  end

  packet_reader_skid_buffer #(
    .W     (WIDTH + 1),
    .DEPTH (SKID_DEPTH),
    .CW    (CW)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (pipe_valid_reg[READ_LATENCY-1]),
    .wr_data ({pipe_last_reg[READ_LATENCY-1], fifo_rd_data}),
    .rd_en   (out_valid && out_ready),
    .head    (skid_head),
    .count   (skid_count),
    .empty   (skid_empty)
  );

  assign fifo_rd_en          = rd_en;
  assign fifo_rd_offset      = rd_en ? issue_cnt_reg[ADDR_BITS-1:0] : '0;
  assign fifo_rd_pop_packet  = pop;
  assign fifo_rd_packet_size = pop ? pkt_len_reg : '0;

  assign out_valid = !skid_empty;
  assign out_data  = skid_empty ? '0 : skid_head[WIDTH-1:0];
  assign out_last  = !skid_empty && skid_head[WIDTH];

  // Reads still in the pipe count as outstanding work.
  assign busy = (state_reg != IDLE) || !skid_empty || (|pipe_valid_reg);

endmodule

// File: tb/tb_packet_fifo_reader.sv
// Directed bench: models the packet FIFO read port and length FIFO, logs every
// handshake at the falling edge and checks each packet against expected values.
module tb_packet_fifo_reader;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int AB    = 10;
  localparam int RL    = 2;
  localparam int SD    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          len_valid;
  logic [AB:0]   len_data;
  logic          len_pop;
  logic [AB:0]   fifo_rd_size;
  logic          fifo_rd_en;
  logic [AB-1:0] fifo_rd_offset;
  logic          fifo_rd_pop_packet;
  logic [AB:0]   fifo_rd_packet_size;
  logic [31:0]   fifo_rd_data;
  logic          out_valid;
  logic [31:0]   out_data;
  logic          out_last;
  logic          out_ready = 1'b1;
  logic          busy;

  always #5 clk = ~clk;

  packet_fifo_reader #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_BITS(AB), .READ_LATENCY(RL), .SKID_DEPTH(SD)
  ) dut (
    .clk(clk), .reset(reset),
    .len_valid(len_valid), .len_data(len_data), .len_pop(len_pop),
    .fifo_rd_size(fifo_rd_size), .fifo_rd_en(fifo_rd_en), .fifo_rd_offset(fifo_rd_offset),
    .fifo_rd_pop_packet(fifo_rd_pop_packet), .fifo_rd_packet_size(fifo_rd_packet_size),
    .fifo_rd_data(fifo_rd_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .busy(busy)
  );

  // Length FIFO model
  int lq [16];
  int lq_head = 0;
  int lq_tail = 0;
  assign len_valid = (lq_head != lq_tail);
  assign len_data  = (AB + 1)'(lq[lq_head]);
  always @(posedge clk) if (len_pop) lq_head <= lq_head + 1;

  // Packet FIFO model: mem[a] = A000_0000 + a, two-register read path
  logic [31:0]   mem [DEPTH];
  int            written = 0;
  int            popped;
  logic [AB-1:0] a_reg;
  logic [31:0]   d_reg;
  assign fifo_rd_size = (AB + 1)'(written - popped);
  assign fifo_rd_data = d_reg;

  initial for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + i;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg  <= '0;
      d_reg  <= '0;
      popped <= 0;
    end else begin
      if (fifo_rd_en) a_reg <= AB'(popped) + fifo_rd_offset;
      d_reg <= mem[a_reg];
      if (fifo_rd_pop_packet) popped <= popped + int'(fifo_rd_packet_size);
    end
  end

  // Event log sampled at the falling edge
  int cyc = 0;
  int lp_cyc[$], rd_cyc[$], rd_off[$], pop_cyc[$], pop_size[$], o_cyc[$];
  logic [31:0] o_data[$];
  bit o_last[$];

  always @(negedge clk) begin
    cyc++;
    if (len_pop) lp_cyc.push_back(cyc);
    if (fifo_rd_en) begin
      rd_cyc.push_back(cyc);
      rd_off.push_back(int'(fifo_rd_offset));
    end
    if (fifo_rd_pop_packet) begin
      pop_cyc.push_back(cyc);
      pop_size.push_back(int'(fifo_rd_packet_size));
    end
    if (out_valid && out_ready) begin
      o_cyc.push_back(cyc);
      o_data.push_back(out_data);
      o_last.push_back(out_last);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic push_len(input int l);
    lq[lq_tail] = l;
    lq_tail++;
  endtask

  task automatic wait_pops(input string tag, input int target);
    for (int i = 0; i < 300 && pop_cyc.size() < target; i++) @(posedge clk);
    #1;
    check({tag, "_pop_timeout"}, pop_cyc.size() >= target, 1);
  endtask

  task automatic wait_outs(input string tag, input int target);
    for (int i = 0; i < 300 && o_cyc.size() < target; i++) @(posedge clk);
    #1;
    check({tag, "_out_timeout"}, o_cyc.size() >= target, 1);
  endtask

  task automatic check_packet(input string tag, input int len, input int lp_i, input int rd_i,
                              input int pop_i, input int o_i, input int base, input bit strict);
    logic [31:0] exp_word;
    if (lp_cyc.size() <= lp_i || rd_cyc.size() < rd_i + len ||
        pop_cyc.size() <= pop_i || o_cyc.size() < o_i + len) begin
      check({tag, "_present"}, 0, 1);
      return;
    end
    check({tag, "_first_rd"}, rd_cyc[rd_i] - lp_cyc[lp_i], 1);
    for (int k = 0; k < len; k++) begin
      exp_word = 32'hA000_0000 + 32'((base + k) % DEPTH);
      check({tag, "_off"}, rd_off[rd_i + k], k);
      check({tag, "_data"}, o_data[o_i + k], exp_word);
      check({tag, "_last"}, o_last[o_i + k], (k == len - 1));
      if (strict) begin
        check({tag, "_rd_gap"}, rd_cyc[rd_i + k] - rd_cyc[rd_i], k);
        check({tag, "_out_gap"}, o_cyc[o_i + k] - o_cyc[o_i], k);
      end
    end
    check({tag, "_pop_size"}, pop_size[pop_i], len);
    check({tag, "_pop_cyc"}, pop_cyc[pop_i] - rd_cyc[rd_i + len - 1], 1);
    $display("pkt %s len %0d base %0d first_rd_cycle %0d pop_cycle %0d",
             tag, len, base, rd_cyc[rd_i], pop_cyc[pop_i]);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1, "timeout");
  end

  initial begin
    int lp0, rd0, p0, o0, max_out, outst;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset state
    @(posedge clk); #1;
    check("rst_len_pop", len_pop, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_rd_off", fifo_rd_offset, 0);
    check("rst_pop", fifo_rd_pop_packet, 0);
    check("rst_pop_size", fifo_rd_packet_size, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // T1: length 4 fully committed, ready high
    lp0 = lp_cyc.size(); rd0 = rd_cyc.size(); p0 = pop_cyc.size(); o0 = o_cyc.size();
    written += 4;
    push_len(4);
    wait_pops("t1", p0 + 1);
    wait_outs("t1", o0 + 4);
    check_packet("t1", 4, lp0, rd0, p0, o0, 0, 1);

    // T2: length 8 with only 5 committed, then the rest arrives
    repeat (3) @(posedge clk);
    #1;
    lp0 = lp_cyc.size(); rd0 = rd_cyc.size(); p0 = pop_cyc.size(); o0 = o_cyc.size();
    written += 5;
    push_len(8);
    repeat (10) @(posedge clk);
    #1;
    check("t2_no_len_pop", lp_cyc.size() - lp0, 0);
    check("t2_no_rd", rd_cyc.size() - rd0, 0);
    check("t2_busy_idle", busy, 0);
    written += 3;
    wait_pops("t2", p0 + 1);
    wait_outs("t2", o0 + 8);
    check_packet("t2", 8, lp0, rd0, p0, o0, 4, 1);

    // T3: length 6 with out_ready pattern 1,0,0,1
    repeat (3) @(posedge clk);
    #1;
    lp0 = lp_cyc.size(); rd0 = rd_cyc.size(); p0 = pop_cyc.size(); o0 = o_cyc.size();
    max_out = 0;
    written += 6;
    push_len(6);
    for (int i = 0; i < 400 && o_cyc.size() < o0 + 6; i++) begin
      @(posedge clk); #1;
      out_ready = pat[i % 4];
      outst = (rd_cyc.size() - rd0) - (o_cyc.size() - o0);
      if (outst > max_out) max_out = outst;
    end
    out_ready = 1'b1;
    wait_pops("t3", p0 + 1);
    wait_outs("t3", o0 + 6);
    repeat (10) @(posedge clk);
    #1;
    check("t3_credit_bound", max_out <= SD, 1);
    check("t3_word_count", o_cyc.size() - o0, 6);
    check_packet("t3", 6, lp0, rd0, p0, o0, 12, 0);

    // T4: zero-length entry then length 3
    lp0 = lp_cyc.size(); rd0 = rd_cyc.size(); p0 = pop_cyc.size(); o0 = o_cyc.size();
    written += 3;
    push_len(0);
    push_len(3);
    wait_pops("t4", p0 + 1);
    wait_outs("t4", o0 + 3);
    repeat (5) @(posedge clk);
    #1;
    check("t4_len_pops", lp_cyc.size() - lp0, 2);
    check("t4_zero_gap", lp_cyc[lp0 + 1] - lp_cyc[lp0], 1);
    check("t4_pops", pop_cyc.size() - p0, 1);
    check("t4_words", o_cyc.size() - o0, 3);
    check_packet("t4", 3, lp0 + 1, rd0, p0, o0, 18, 1);

    // T5: reset during READ after two of five reads
    lp0 = lp_cyc.size(); rd0 = rd_cyc.size(); p0 = pop_cyc.size(); o0 = o_cyc.size();
    written += 5;
    push_len(5);
    for (int i = 0; i < 100 && rd_cyc.size() < rd0 + 2; i++) @(negedge clk);
    check("t5_two_reads", rd_cyc.size() >= rd0 + 2, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    written = 0;
    #1;
    check("t5_rd_en", fifo_rd_en, 0);
    check("t5_rd_off", fifo_rd_offset, 0);
    check("t5_pop", fifo_rd_pop_packet, 0);
    check("t5_out_valid", out_valid, 0);
    check("t5_out_data", out_data, 0);
    check("t5_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    lp0 = lp_cyc.size(); rd0 = rd_cyc.size();
    repeat (5) @(posedge clk);
    #1;
    check("t5_no_pop", pop_cyc.size() - p0, 0);
    check("t5_idle_len_pop", lp_cyc.size() - lp0, 0);
    check("t5_idle_rd", rd_cyc.size() - rd0, 0);
    check("t5_idle_busy", busy, 0);

    // T6: three single-word packets back to back
    lp0 = lp_cyc.size(); rd0 = rd_cyc.size(); p0 = pop_cyc.size(); o0 = o_cyc.size();
    written += 3;
    push_len(1);
    push_len(1);
    push_len(1);
    wait_pops("t6", p0 + 3);
    wait_outs("t6", o0 + 3);
    for (int k = 0; k < 3; k++) check_packet("t6", 1, lp0 + k, rd0 + k, p0 + k, o0 + k, k, 1);
    if (pop_cyc.size() >= p0 + 3) begin
      check("t6_pop_space0", pop_cyc[p0 + 1] - pop_cyc[p0], 3);
      check("t6_pop_space1", pop_cyc[p0 + 2] - pop_cyc[p0 + 1], 3);
    end else begin
      check("t6_pop_count", pop_cyc.size() - p0, 3);
    end

    repeat (5) @(posedge clk);
    #1;
    check("end_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
